// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the D->E pipeline bundle.
// Imported by the decode section, its register file and its interface.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OP     = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  localparam logic [3:0] RSP      = 4'h4;
  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [2:0] S_AOK    = 3'd1;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] pc;
    logic [63:0] val_c;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic        br_taken;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    stat:     S_AOK,
    icode:    I_NOP,
    ifun:     4'h0,
    pc:       64'h0,
    val_c:    64'h0,
    val_a:    64'h0,
    val_b:    64'h0,
    dst_e:    RNONE,
    dst_m:    RNONE,
    src_a:    RNONE,
    src_b:    RNONE,
    br_taken: 1'b0
  };

endpackage

// File: rtl/y86_decode_section_if.sv
// Forwarding bus from the E/M/W stages into decode.
// master: later stages drive dst/val pairs; slave: decode consumes them.
interface y86_decode_section_if;
  import y86_pkg::*;

  logic [3:0]  e_dstE_i;
  logic [63:0] e_valE_i;
  logic [3:0]  M_dstE_i;
  logic [63:0] M_valE_i;
  logic [3:0]  M_dstM_i;
  logic [63:0] m_valM_i;
  logic [3:0]  W_dstE_i;
  logic [63:0] W_valE_i;
  logic [3:0]  W_dstM_i;
  logic [63:0] W_valM_i;

  modport master (
    output e_dstE_i, e_valE_i,
    output M_dstE_i, M_valE_i,
    output M_dstM_i, m_valM_i,
    output W_dstE_i, W_valE_i,
    output W_dstM_i, W_valM_i
  );

  modport slave (
    input e_dstE_i, e_valE_i,
    input M_dstE_i, M_valE_i,
    input M_dstM_i, m_valM_i,
    input W_dstE_i, W_valE_i,
    input W_dstM_i, W_valM_i
  );

endinterface

// File: rtl/y86_regfile.sv
// 15x64 register file: two combinational reads, two writes per edge.
// Ports: src_a/src_b -> rd_a/rd_b; (dst_e,val_e),(dst_m,val_m) writes.
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] rd_a,
  output logic [63:0] rd_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs [15];

  // M write is issued last so it wins on a shared target.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= 64'h0;
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

  assign rd_a = (src_a == RNONE) ? 64'h0 : regs[src_a];
  assign rd_b = (src_b == RNONE) ? 64'h0 : regs[src_b];

endmodule

// File: rtl/y86_decode_section.sv
// F predicted-PC register, decode stage with forwarding, D->E register.
// Ports: F control/PC, D fields, forwarding bus (fwd), E-register fields.
module y86_decode_section
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        F_stall_i,
  input  logic        F_bubble_i,
  input  logic [63:0] f_predPC_i,
  output logic [63:0] F_predPC_o,
  input  logic [63:0] D_PC_i,
  input  logic [63:0] D_valC_i,
  input  logic [63:0] D_valP_i,
  input  logic [2:0]  D_stat_i,
  input  logic [3:0]  D_icode_i,
  input  logic [3:0]  D_ifun_i,
  input  logic [3:0]  D_rA_i,
  input  logic [3:0]  D_rB_i,
  input  logic        D_branch_taken_i,
  y86_decode_section_if.slave fwd,
  input  logic        E_stall_i,
  input  logic        E_bubble_i,
  output logic [3:0]  d_srcA_o,
  output logic [3:0]  d_srcB_o,
  output logic [63:0] E_PC_o,
  output logic [63:0] E_valC_o,
  output logic [63:0] E_valA_o,
  output logic [63:0] E_valB_o,
  output logic [2:0]  E_stat_o,
  output logic [3:0]  E_icode_o,
  output logic [3:0]  E_ifun_o,
  output logic [3:0]  E_dstE_o,
  output logic [3:0]  E_dstM_o,
  output logic [3:0]  E_srcA_o,
  output logic [3:0]  E_srcB_o,
  output logic        E_branch_taken_o
);

  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] rf_a, rf_b, val_a, val_b;
  id_ex_t      e_q, e_d;

  always_ff @(posedge clk_i) begin
    if (rst_i || F_bubble_i) F_predPC_o <= RESET_PC;
    else if (!F_stall_i)     F_predPC_o <= f_predPC_i;
  end

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (D_icode_i)
      I_RRMOV: begin src_a = D_rA_i; dst_e = D_rB_i; end
      I_IRMOV: dst_e = D_rB_i;
      I_RMMOV: begin src_a = D_rA_i; src_b = D_rB_i; end
      I_MRMOV: begin src_b = D_rB_i; dst_m = D_rA_i; end
      I_OP: begin
        src_a = D_rA_i;
        src_b = D_rB_i;
        dst_e = D_rB_i;
      end
      I_CALL: begin src_b = RSP; dst_e = RSP; end
      I_RET: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
      end
      I_PUSH: begin
        src_a = D_rA_i;
        src_b = RSP;
        dst_e = RSP;
      end
      I_POP: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
        dst_m = D_rA_i;
      end
      default: ;
    endcase
  end

  assign d_srcA_o = src_a;
  assign d_srcB_o = src_b;

  y86_regfile u_rf (
    .clk   (clk_i),
    .rst   (rst_i),
    .src_a (src_a),
    .src_b (src_b),
    .rd_a  (rf_a),
    .rd_b  (rf_b),
    .dst_e (fwd.W_dstE_i),
    .val_e (fwd.W_valE_i),
    .dst_m (fwd.W_dstM_i),
    .val_m (fwd.W_valM_i)
  );

  // A non-RNONE source can only match a non-RNONE destination,
  // so RNONE is filtered once up front.
  always_comb begin
    val_a = rf_a;
    if (D_icode_i == I_CALL || D_icode_i == I_JXX)
      val_a = D_valP_i;
    else if (src_a == RNONE)        val_a = 64'h0;
    else if (src_a == fwd.e_dstE_i) val_a = fwd.e_valE_i;
    else if (src_a == fwd.M_dstM_i) val_a = fwd.m_valM_i;
    else if (src_a == fwd.M_dstE_i) val_a = fwd.M_valE_i;
    else if (src_a == fwd.W_dstM_i) val_a = fwd.W_valM_i;
    else if (src_a == fwd.W_dstE_i) val_a = fwd.W_valE_i;
  end

  always_comb begin
    val_b = rf_b;
    if (src_b == RNONE)             val_b = 64'h0;
    else if (src_b == fwd.e_dstE_i) val_b = fwd.e_valE_i;
    else if (src_b == fwd.M_dstM_i) val_b = fwd.m_valM_i;
    else if (src_b == fwd.M_dstE_i) val_b = fwd.M_valE_i;
    else if (src_b == fwd.W_dstM_i) val_b = fwd.W_valM_i;
    else if (src_b == fwd.W_dstE_i) val_b = fwd.W_valE_i;
  end

  always_comb begin
    e_d          = ID_EX_BUBBLE;
    e_d.stat     = D_stat_i;
    e_d.icode    = D_icode_i;
    e_d.ifun     = D_ifun_i;
    e_d.pc       = D_PC_i;
    e_d.val_c    = D_valC_i;
    e_d.val_a    = val_a;
    e_d.val_b    = val_b;
    e_d.dst_e    = dst_e;
    e_d.dst_m    = dst_m;
    e_d.src_a    = src_a;
    e_d.src_b    = src_b;
    e_d.br_taken = D_branch_taken_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || E_bubble_i) e_q <= ID_EX_BUBBLE;
    else if (!E_stall_i)     e_q <= e_d;
  end

  assign E_PC_o           = e_q.pc;
  assign E_valC_o         = e_q.val_c;
  assign E_valA_o         = e_q.val_a;
  assign E_valB_o         = e_q.val_b;
  assign E_stat_o         = e_q.stat;
  assign E_icode_o        = e_q.icode;
  assign E_ifun_o         = e_q.ifun;
  assign E_dstE_o         = e_q.dst_e;
  assign E_dstM_o         = e_q.dst_m;
  assign E_srcA_o         = e_q.src_a;
  assign E_srcB_o         = e_q.src_b;
  assign E_branch_taken_o = e_q.br_taken;

endmodule

// File: tb/tb_y86_decode_section.sv
// Directed table-driven bench for y86_decode_section.
// Drives D fields and forwarding bus; checks srcs and E register.
module tb_y86_decode_section;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall, F_bubble;
  logic [63:0] f_predPC, F_predPC;
  logic [63:0] D_PC, D_valC, D_valP;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic        D_bt;
  logic        E_stall, E_bubble;
  logic [3:0]  d_srcA, d_srcB;
  logic [63:0] E_PC, E_valC, E_valA, E_valB;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic        E_bt;

  int checks = 0;
  int errors = 0;

  y86_decode_section_if fwd ();

  always #5 clk = ~clk;

  y86_decode_section dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .F_stall_i        (F_stall),
    .F_bubble_i       (F_bubble),
    .f_predPC_i       (f_predPC),
    .F_predPC_o       (F_predPC),
    .D_PC_i           (D_PC),
    .D_valC_i         (D_valC),
    .D_valP_i         (D_valP),
    .D_stat_i         (D_stat),
    .D_icode_i        (D_icode),
    .D_ifun_i         (D_ifun),
    .D_rA_i           (D_rA),
    .D_rB_i           (D_rB),
    .D_branch_taken_i (D_bt),
    .fwd              (fwd.slave),
    .E_stall_i        (E_stall),
    .E_bubble_i       (E_bubble),
    .d_srcA_o         (d_srcA),
    .d_srcB_o         (d_srcB),
    .E_PC_o           (E_PC),
    .E_valC_o         (E_valC),
    .E_valA_o         (E_valA),
    .E_valB_o         (E_valB),
    .E_stat_o         (E_stat),
    .E_icode_o        (E_icode),
    .E_ifun_o         (E_ifun),
    .E_dstE_o         (E_dstE),
    .E_dstM_o         (E_dstM),
    .E_srcA_o         (E_srcA),
    .E_srcB_o         (E_srcB),
    .E_branch_taken_o (E_bt)
  );

  typedef struct {
    logic [3:0]  ic, ra, rb;
    logic [63:0] vc, vp;
    logic [3:0]  ed;  logic [63:0] ev;
    logic [3:0]  mdm; logic [63:0] mvm;
    logic [3:0]  mde; logic [63:0] mve;
    logic [3:0]  wde; logic [63:0] wve;
    logic [3:0]  wdm; logic [63:0] wvm;
    logic [63:0] xa, xb;
    logic [3:0]  xsa, xsb, xde, xdm;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr_fwd();
    fwd.e_dstE_i = RNONE; fwd.e_valE_i = 64'h0;
    fwd.M_dstE_i = RNONE; fwd.M_valE_i = 64'h0;
    fwd.M_dstM_i = RNONE; fwd.m_valM_i = 64'h0;
    fwd.W_dstE_i = RNONE; fwd.W_valE_i = 64'h0;
    fwd.W_dstM_i = RNONE; fwd.W_valM_i = 64'h0;
  endtask

  task automatic set_d(input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc,
                       input logic [63:0] vp);
    D_icode = ic; D_ifun = 4'h0; D_rA = ra; D_rB = rb;
    D_valC = vc; D_valP = vp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; F_stall = 1'b0; F_bubble = 1'b0; f_predPC = 64'h0;
    E_stall = 1'b0; E_bubble = 1'b0;
    D_PC = 64'h0; D_stat = S_AOK; D_bt = 1'b0;
    set_d(I_NOP, RNONE, RNONE, 64'h0, 64'h0);
    clr_fwd();

    tbl[0]  = '{I_OP, 4'h2, 4'h3, 64'h0, 64'h0,
                4'h2, 64'hA, 4'h2, 64'hB, RNONE, 64'h0,
                4'h2, 64'hC, RNONE, 64'h0,
                64'hA, 64'h55, 4'h2, 4'h3, 4'h3, RNONE};
    tbl[1]  = '{I_OP, 4'h2, 4'h3, 64'h0, 64'h0,
                RNONE, 64'h0, 4'h2, 64'hB, RNONE, 64'h0,
                4'h2, 64'hC, RNONE, 64'h0,
                64'hB, 64'h55, 4'h2, 4'h3, 4'h3, RNONE};
    tbl[2]  = '{I_RRMOV, 4'h2, 4'h5, 64'h0, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0,
                64'hC, 64'h0, 4'h2, RNONE, 4'h5, RNONE};
    tbl[3]  = '{I_CALL, RNONE, RNONE, 64'h0, 64'h100,
                RNONE, 64'h0, RNONE, 64'h0, 4'h4, 64'h200,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h100, 64'h200, RNONE, 4'h4, 4'h4, RNONE};
    tbl[4]  = '{I_PUSH, 4'h3, RNONE, 64'h0, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h55, 64'h0, 4'h3, 4'h4, 4'h4, RNONE};
    tbl[5]  = '{I_POP, 4'h7, RNONE, 64'h0, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, 4'h4, 64'h77,
                64'h77, 64'h77, 4'h4, 4'h4, 4'h4, 4'h7};
    tbl[6]  = '{I_MRMOV, 4'h1, 4'h6, 64'h18, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h0, 64'h0, RNONE, 4'h6, RNONE, 4'h1};
    tbl[7]  = '{I_IRMOV, RNONE, 4'h9, 64'h33, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h0, 64'h0, RNONE, RNONE, 4'h9, RNONE};
    tbl[8]  = '{I_RET, RNONE, RNONE, 64'h0, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h77, 64'h77, 4'h4, 4'h4, 4'h4, RNONE};
    tbl[9]  = '{I_JXX, RNONE, RNONE, 64'h0, 64'h40,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h40, 64'h0, RNONE, RNONE, RNONE, RNONE};
    tbl[10] = '{I_OP, 4'h8, 4'h8, 64'h0, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, 4'h8, 64'h81,
                RNONE, 64'h0, 4'h8, 64'h82,
                64'h81, 64'h81, 4'h8, 4'h8, 4'h8, RNONE};
    tbl[11] = '{I_OP, 4'h8, 4'h8, 64'h0, 64'h0,
                RNONE, 64'h0, 4'h8, 64'h91, 4'h8, 64'h92,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h91, 64'h91, 4'h8, 4'h8, 4'h8, RNONE};
    tbl[12] = '{I_OP, 4'h8, 4'h8, 64'h0, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                4'h8, 64'h83, RNONE, 64'h0,
                64'h83, 64'h83, 4'h8, 4'h8, 4'h8, RNONE};
    tbl[13] = '{I_OP, 4'h8, 4'h8, 64'h0, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h83, 64'h83, 4'h8, 4'h8, 4'h8, RNONE};
    tbl[14] = '{I_HALT, 4'h1, 4'h2, 64'h0, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h0, 64'h0, RNONE, RNONE, RNONE, RNONE};
    tbl[15] = '{I_RMMOV, 4'h8, 4'h3, 64'h0, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0, RNONE, 64'h0,
                RNONE, 64'h0, RNONE, 64'h0,
                64'h83, 64'h55, 4'h8, 4'h3, RNONE, RNONE};

    tick(); tick();
    chk("rst_fpc", F_predPC, 64'h0);
    chk("rst_icode", E_icode, {60'h0, I_NOP});
    chk("rst_dstE", E_dstE, {60'h0, RNONE});
    rst = 1'b0;

    for (int r = 0; r < 15; r++) begin
      set_d(I_OP, 4'(r), 4'(r), 64'h0, 64'h0);
      tick();
      chk($sformatf("rst_reg%0d", r), E_valA, 64'h0);
    end

    set_d(I_NOP, RNONE, RNONE, 64'h0, 64'h0);
    fwd.W_dstE_i = 4'h3; fwd.W_valE_i = 64'h55;
    tick();
    clr_fwd();
    set_d(I_OP, 4'h3, 4'h3, 64'h0, 64'h0);
    tick();
    chk("rf_valA", E_valA, 64'h55);
    chk("rf_valB", E_valB, 64'h55);
    chk("rf_dstE", E_dstE, 64'h3);

    for (int i = 0; i < 16; i++) begin
      set_d(tbl[i].ic, tbl[i].ra, tbl[i].rb, tbl[i].vc, tbl[i].vp);
      D_PC = 64'h1000 + 64'(i);
      fwd.e_dstE_i = tbl[i].ed;  fwd.e_valE_i = tbl[i].ev;
      fwd.M_dstM_i = tbl[i].mdm; fwd.m_valM_i = tbl[i].mvm;
      fwd.M_dstE_i = tbl[i].mde; fwd.M_valE_i = tbl[i].mve;
      fwd.W_dstE_i = tbl[i].wde; fwd.W_valE_i = tbl[i].wve;
      fwd.W_dstM_i = tbl[i].wdm; fwd.W_valM_i = tbl[i].wvm;
      #1;
      chk($sformatf("v%0d_srcA", i), d_srcA, tbl[i].xsa);
      chk($sformatf("v%0d_srcB", i), d_srcB, tbl[i].xsb);
      tick();
      chk($sformatf("v%0d_valA", i), E_valA, tbl[i].xa);
      chk($sformatf("v%0d_valB", i), E_valB, tbl[i].xb);
      chk($sformatf("v%0d_dstE", i), E_dstE, tbl[i].xde);
      chk($sformatf("v%0d_dstM", i), E_dstM, tbl[i].xdm);
      chk($sformatf("v%0d_icode", i), E_icode, tbl[i].ic);
      chk($sformatf("v%0d_valC", i), E_valC, tbl[i].vc);
      chk($sformatf("v%0d_PC", i), E_PC, 64'h1000 + 64'(i));
      clr_fwd();
    end

    set_d(I_NOP, RNONE, RNONE, 64'h0, 64'h0);
    fwd.W_dstE_i = 4'h4; fwd.W_valE_i = 64'h10;
    fwd.W_dstM_i = 4'h4; fwd.W_valM_i = 64'h20;
    tick();
    clr_fwd();
    set_d(I_RET, RNONE, RNONE, 64'h0, 64'h0);
    tick();
    chk("same_edge_rsp", E_valA, 64'h20);

    set_d(I_OP, 4'h3, 4'h8, 64'h77, 64'h0);
    D_ifun = 4'h2; D_stat = 3'd3; D_bt = 1'b1; D_PC = 64'h500;
    tick();
    chk("ld_stat", E_stat, 64'h3);
    chk("ld_bt", E_bt, 64'h1);
    E_stall = 1'b1;
    set_d(I_IRMOV, RNONE, 4'h2, 64'h99, 64'h0);
    D_stat = S_AOK; D_bt = 1'b0; D_PC = 64'h600;
    tick();
    chk("stall_icode", E_icode, {60'h0, I_OP});
    chk("stall_ifun", E_ifun, 64'h2);
    chk("stall_valA", E_valA, 64'h55);
    chk("stall_valB", E_valB, 64'h83);
    chk("stall_PC", E_PC, 64'h500);
    chk("stall_stat", E_stat, 64'h3);
    chk("stall_bt", E_bt, 64'h1);
    chk("stall_srcB", E_srcB, 64'h8);
    E_stall = 1'b0; E_bubble = 1'b1;
    tick();
    E_bubble = 1'b0;
    chk("bub_icode", E_icode, {60'h0, I_NOP});
    chk("bub_stat", E_stat, {61'h0, S_AOK});
    chk("bub_dstE", E_dstE, {60'h0, RNONE});
    chk("bub_srcA", E_srcA, {60'h0, RNONE});
    chk("bub_valC", E_valC, 64'h0);
    chk("bub_bt", E_bt, 64'h0);

    f_predPC = 64'h40;
    tick();
    chk("f_load", F_predPC, 64'h40);
    F_stall = 1'b1; f_predPC = 64'h48;
    tick();
    chk("f_stall", F_predPC, 64'h40);
    F_stall = 1'b0;
    tick();
    chk("f_release", F_predPC, 64'h48);
    F_bubble = 1'b1;
    tick();
    F_bubble = 1'b0;
    chk("f_bubble", F_predPC, 64'h0);

    tick();
    F_stall = 1'b1; E_stall = 1'b1; rst = 1'b1;
    tick();
    chk("mid_rst_fpc", F_predPC, 64'h0);
    chk("mid_rst_icode", E_icode, {60'h0, I_NOP});
    rst = 1'b0; F_stall = 1'b0; E_stall = 1'b0;
    set_d(I_RET, RNONE, RNONE, 64'h0, 64'h0);
    tick();
    chk("mid_rst_rsp", E_valA, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1);
  end

endmodule

// File: doc/y86_decode_section.md
Name: y86_decode_section

Overview:
- Front-middle section of the 5-stage Y86-64 pipeline.
- Contains the F-stage predicted-PC register, the decode stage, and the D→E pipeline register.
- Decode stage: 15×64-bit register file, src/dst selection, five-source forwarding.
- Consumes D-register fields plus E/M/W forwarding buses; produces F_predPC and the E-register fields.

Parameters:
- RESET_PC, 64'h0, reset/bubble value of F_predPC.

Ports:
- clk_i in 1: clock, all state updates on rising edge.
- rst_i in 1: reset, synchronous, active-high.
- F_stall_i in 1: hold F_predPC.
- F_bubble_i in 1: load RESET_PC into F_predPC.
- f_predPC_i in 64: next predicted PC.
- F_predPC_o out 64: registered predicted PC.
- D_PC_i, D_valC_i, D_valP_i in 64 each: decode-stage PC, constant, next PC.
- D_stat_i in 3: decode-stage status.
- D_icode_i, D_ifun_i, D_rA_i, D_rB_i in 4 each: decode-stage instruction fields.
- D_branch_taken_i in 1: predictor decision.
- e_dstE_i in 4, e_valE_i in 64: execute forward.
- M_dstE_i in 4, M_valE_i in 64: memory-stage ALU forward.
- M_dstM_i in 4, m_valM_i in 64: memory-read forward.
- W_dstE_i in 4, W_valE_i in 64: writeback E port.
- W_dstM_i in 4, W_valM_i in 64: writeback M port.
- E_stall_i in 1, E_bubble_i in 1: E-register control.
- d_srcA_o, d_srcB_o out 4: combinational, to hazard control.
- E_PC_o, E_valC_o, E_valA_o, E_valB_o out 64 each: E-register data.
- E_stat_o out 3: E-register status.
- E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o out 4 each: E-register fields.
- E_branch_taken_o out 1: E-register predictor decision.

Behaviour:
- Encodings: icodes HALT0 NOP1 RRMOV2 IRMOV3 RMMOV4 MRMOV5 OP6 JXX7 CALL8 RET9 PUSHA POPB; RSP=4; RNONE=F; stat AOK=1.
- srcA = rA for RRMOV/RMMOV/OP/PUSH; RSP for POP/RET; else RNONE.
- srcB = rB for OP/RMMOV/MRMOV; RSP for PUSH/POP/CALL/RET; else RNONE.
- dstE = rB for RRMOV/IRMOV/OP; RSP for PUSH/POP/CALL/RET; else RNONE. Conditional-move suppression happens in execute, not here.
- dstM = rA for MRMOV/POP; else RNONE.
- valA:
  - CALL/JXX → D_valP_i.
  - Otherwise forward on srcA with first match winning: e_dstE→e_valE; M_dstM→m_valM; M_dstE→M_valE; W_dstM→W_valM; W_dstE→W_valE; else register-file read.
  - A source of RNONE never matches; valA is 0 when srcA=RNONE.
- valB: identical priority chain on srcB, no valP path; 0 when srcB=RNONE.
- Register file:
  - Combinational read.
  - Rising-edge writes: W_valE→W_dstE, W_valM→W_dstM, each unless RNONE. If both target the same register, W_valM wins.
  - Same-cycle read-during-write returns the value supplied by the W forward path.
  - Reset clears all 15 registers to 0.
- F register priority: rst_i or F_bubble_i → RESET_PC; else F_stall_i holds; else loads f_predPC_i.
- E register priority: rst_i or E_bubble_i → bubble; else E_stall_i holds; else loads D_* and d_* values.
  - Bubble contents: icode=NOP, ifun=0, stat=AOK, dst/src=RNONE, PC/valC/valA/valB=0, branch_taken=0.
- Latency: one cycle from D inputs to E outputs. No handshake.
- Reset asserted mid-operation takes effect at the next edge regardless of stall inputs.

Decomposition:
- Shared package y86_pkg: icode/stat/register constants, RNONE, RSP.
- One sub-module: y86_regfile (15×64, two combinational read ports, two write ports, M-port priority).

Test Plan:
- Reset: hold rst_i 2 cycles → F_predPC_o=0; E_icode_o=1; E_dstE_o=F; all registers read 0.
- Regfile: W_dstE=3, W_valE=0x55 for one edge, then D OP rA=3 rB=3 → E_valA=E_valB=0x55, E_dstE=3.
- Forwarding priority: srcA=2 with e_dstE=2/0xA, M_dstM=2/0xB, W_dstE=2/0xC → valA=0xA. Drop e_dstE → 0xB.
- CALL with valP=0x100 and rsp forwarded 0x200 → E_valA=0x100, E_valB=0x200, E_dstE=4.
- Same-edge write: W_dstE=4/0x10 and W_dstM=4/0x20 → later read of rsp=0x20.
- Stall/bubble: E_stall holds all E outputs one cycle; E_bubble → NOP bubble; F_stall holds 0x40 while f_predPC_i=0x48.
